// File: rtl/csa_resolve_adder_if.sv
// Operand/result handshake bundle between the Wallace tree, the carry-resolve
// stage and the posit normaliser.
interface csa_resolve_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] pp0;
    logic [WIDTH-1:0] pp1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_zero;

    modport slave (
        input  in_valid, pp0, pp1, out_ready,
        output in_ready, out_valid, out_sum, out_zero
    );

    modport master (
        output in_valid, pp0, pp1, out_ready,
        input  in_ready, out_valid, out_sum, out_zero
    );
endinterface

// File: rtl/csa_resolve_adder.sv
// Multi-cycle carry-propagate adder: resolves two carry-save rows into the
// final product, SEG bits per cycle, with valid/ready on both sides.
module csa_resolve_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic              clk,
    input  logic              rst,
    csa_resolve_adder_if.slave bus
);
    localparam int NSEG = WIDTH / SEG;
    localparam int SEGW = (NSEG > 1) ? $clog2(NSEG) : 1;

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $error("csa_resolve_adder: WIDTH must be a multiple of SEG");
    end

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a, b, res, res_next;
    logic [SEGW-1:0]  seg;
    logic             carry;
    logic [SEG:0]     seg_sum;
    logic             last;
    logic             accept;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic             out_zero;

    assign seg_sum = {1'b0, a[seg*SEG +: SEG]} + {1'b0, b[seg*SEG +: SEG]} + {{SEG{1'b0}}, carry};
    assign last    = (seg == SEGW'(NSEG - 1));

    always_comb begin
        res_next = res;
        res_next[seg*SEG +: SEG] = seg_sum[SEG-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                // Result drain and next operand accept may share one edge.
                in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        accept     = 1'b1;
                        state_next = ADD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a         <= '0;
            b         <= '0;
            res       <= '0;
            seg       <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_zero  <= 1'b0;
        end else begin
            if (accept) begin
                a     <= bus.pp0;
                b     <= bus.pp1;
                res   <= '0;
                seg   <= '0;
                carry <= 1'b0;
            end
            if (state == ADD) begin
                res   <= res_next;
                carry <= seg_sum[SEG];
                seg   <= seg + 1'b1;
                // Top-segment carry is intentionally dropped (modular result).
                if (last) begin
                    out_valid <= 1'b1;
                    out_sum   <= res_next;
                    out_zero  <= (res_next == '0);
                end
            end
            if (state == DONE && bus.out_ready) out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_sum;
    assign bus.out_zero  = out_zero;
endmodule

// File: tb/tb_csa_resolve_adder.sv
// Directed and randomized checks of csa_resolve_adder against a modular-add
// reference model with an in-order scoreboard.
module tb_csa_resolve_adder;
    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int NSEG  = WIDTH / SEG;
    localparam int NRAND = 1000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    csa_resolve_adder_if #(.WIDTH(WIDTH)) bus ();

    csa_resolve_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int unsigned s;
        s = int'(x) + int'(y);
        return WIDTH'(s % (1 << WIDTH));
    endfunction

    // Returns edges from now until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (bus.out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Accept one operand pair from IDLE and wait for its result (out_ready low).
    task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int cyc;
        bus.pp0      = x;
        bus.pp1      = y;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.pp0      = ~x;
        bus.pp1      = ~y;
        chk({tag, "_busy_in_ready"}, bus.in_ready, 0);
        wait_valid(cyc);
        chk({tag, "_latency"}, cyc, NSEG);
        chk({tag, "_sum"}, bus.out_sum, ref_sum(x, y));
        chk({tag, "_zero"}, bus.out_zero, ref_sum(x, y) == 0);
    endtask

    initial begin
        int cyc;
        int seen;
        logic [WIDTH-1:0] exp_q[$];
        logic [WIDTH-1:0] x, y, held;
        int sent, recv, cycles;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.pp0 = '0;
        bus.pp1 = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_zero", bus.out_zero, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // Negative result
        run_op("neg", 16'hFFF0, 16'h0001);
        chk("neg_lit", bus.out_sum, 16'hFFF1);
        bus.out_ready = 1'b1;
        tick();
        chk("neg_drain_valid", bus.out_valid, 0);
        chk("neg_idle_ready", bus.in_ready, 1);

        // Carry ripples through every segment
        run_op("ripple", 16'hFFFF, 16'h0001);
        chk("ripple_zero_lit", bus.out_zero, 1);
        bus.out_ready = 1'b1;
        tick();

        // Backpressure
        run_op("bp", 16'h1200, 16'h0034);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_sum", bus.out_sum, 16'h1234);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_done_ready", bus.in_ready, 1);
        tick();
        chk("bp_drain_valid", bus.out_valid, 0);
        chk("bp_idle_ready", bus.in_ready, 1);

        // Back-to-back: drain and accept on one edge
        run_op("b2b_a", 16'h0001, 16'h0002);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.pp0 = 16'h0100;
        bus.pp1 = 16'h00FF;
        #1;
        chk("b2b_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_drained", bus.out_valid, 0);
        chk("b2b_busy", bus.in_ready, 0);
        wait_valid(cyc);
        chk("b2b_latency", cyc, NSEG);
        chk("b2b_sum", bus.out_sum, 16'h01FF);
        bus.out_ready = 1'b1;
        tick();

        // Reset in the middle of an operation
        bus.out_ready = 1'b0;
        bus.pp0 = 16'h7FFF;
        bus.pp1 = 16'h0001;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_sum", bus.out_sum, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("mid_rst_no_emit", seen, 0);

        // Random regression with scoreboard
        sent = 0;
        recv = 0;
        cycles = 0;
        held = '0;
        while (recv < NRAND && cycles < 40000) begin
            cycles++;
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            if ($urandom_range(0, 7) == 0) x = '1;
            if ($urandom_range(0, 7) == 0) y = WIDTH'(~x + 1'b1);
            bus.pp0 = x;
            bus.pp1 = y;
            bus.in_valid = (sent < NRAND) && ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.out_valid && bus.out_sum !== held) chk("rand_hold", bus.out_sum, held);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_sum(x, y));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_extra", 1, 0);
                end else begin
                    chk("rand_sum", bus.out_sum, exp_q[0]);
                    chk("rand_zero", bus.out_zero, exp_q[0] == 0);
                    void'(exp_q.pop_front());
                end
                recv++;
            end
            tick();
            if (bus.out_valid) held = bus.out_sum;
        end
        bus.in_valid = 1'b0;
        chk("rand_count", recv, NRAND);
        chk("rand_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
